// File: rtl/seg7_pattern_reader_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment readback blocks.
//   SEG7_PATTERNS : active-low segment pattern (g..a) for each hex value 0..F
//   SEG7_BLANK    : all-segments-off pattern
//   seg7_state_e  : stability-filter FSM states
package seg7_pkg;

  localparam logic [6:0] SEG7_PATTERNS [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HELD
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_reader_if.sv
// seg7_pattern_reader_if: segment sample input and decoded-result valid/ready output.
//   seg_valid/seg_data/seg_digit : sample strobe, active-low pattern (g..a), display index
//   out_valid/out_ready          : result handshake
//   out_value/out_digit/out_illegal : decoded result
//   out_blank                    : only when SEG7_BLANK_EN is defined
// Modports: master = sample producer / result consumer, slave = reader.
interface seg7_pattern_reader_if;
  logic       seg_valid;
  logic [6:0] seg_data;
  logic [2:0] seg_digit;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_value;
  logic [2:0] out_digit;
  logic       out_illegal;
`ifdef SEG7_BLANK_EN
  logic       out_blank;
`endif

  modport master (
    output seg_valid, seg_data, seg_digit, out_ready,
    input  out_valid, out_value, out_digit, out_illegal
`ifdef SEG7_BLANK_EN
    , input out_blank
`endif
  );

  modport slave (
    input  seg_valid, seg_data, seg_digit, out_ready,
    output out_valid, out_value, out_digit, out_illegal
`ifdef SEG7_BLANK_EN
    , output out_blank
`endif
  );
endinterface

// File: rtl/seg7_pattern_reader_lookup.sv
// seg7_pattern_lookup: combinational active-low segment pattern -> hex value.
//   pattern_i : segment pattern g..a (active low)
//   value_o   : decoded hex value, 0 when the pattern is not in the table
//   illegal_o : pattern is not one of the 16 hex glyphs
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] value_o,
  output logic       illegal_o
);

  always_comb begin
    value_o   = '0;
    illegal_o = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern_i == SEG7_PATTERNS[i]) begin
        value_o   = 4'(i);
        illegal_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_pattern_reader.sv
// seg7_pattern_reader: readback monitor for the seven-segment drive path.
// Filters sampled segment patterns for stability, decodes each stable pattern
// to hex, delivers it over a valid/ready output and mirrors HEX0..HEX5 in a
// shadow register.
//   CLOCK_50 : clock, rising edge
//   resetn   : asynchronous active-low reset
//   bus      : seg7_pattern_reader_if.slave (samples in, results out)
//   digits   : nibble k = last legal value accepted for display k
//   overflow : sticky, set when a result is dropped because out was stalled
// Optional macro SEG7_BLANK_EN: accept 1111111 as a legal blank glyph
// (out_blank=1, out_illegal=0, shadow register not touched).
module seg7_pattern_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = 4,
  parameter int unsigned NUM_DIGITS   = 6
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  seg7_pattern_reader_if.slave    bus,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    overflow
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_COUNT);
  localparam logic [3:0] NDIG_W   = 4'(NUM_DIGITS);

  seg7_state_e            state_q, state_d;
  logic [9:0]             samp_q, samp_d;    // {digit, data}
  logic [7:0]             count_q, count_d;
  logic                   accept;
  logic                   sample_ok;
  logic                   same;
  logic [9:0]             sample;

  logic [3:0]             lk_value;
  logic                   lk_illegal;
  logic                   res_illegal;

  logic                   out_valid_q;
  logic [3:0]             out_value_q;
  logic [2:0]             out_digit_q;
  logic                   out_illegal_q;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic                   overflow_q;

  seg7_pattern_lookup u_lookup (
    .pattern_i (bus.seg_data),
    .value_o   (lk_value),
    .illegal_o (lk_illegal)
  );

`ifdef SEG7_BLANK_EN
  logic is_blank;
  logic out_blank_q;
  assign is_blank    = (bus.seg_data == SEG7_BLANK);
  assign res_illegal = lk_illegal & ~is_blank;
  assign bus.out_blank = out_blank_q;
`else
  assign res_illegal = lk_illegal;
`endif

  assign sample    = {bus.seg_digit, bus.seg_data};
  // Out-of-range digits are invisible to the filter so they cannot break a run.
  assign sample_ok = bus.seg_valid && ({1'b0, bus.seg_digit} < NDIG_W);
  assign same      = (sample == samp_q);

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    count_d = count_q;
    accept  = 1'b0;
    if (sample_ok) begin
      if (state_q == IDLE || !same) begin
        // New run: with STABLE_COUNT == 1 the first sample already qualifies.
        samp_d  = sample;
        count_d = 8'd1;
        if (STABLE_W == 8'd1) begin
          accept  = 1'b1;
          state_d = HELD;
        end else begin
          state_d = COUNT;
        end
      end else if (state_q == COUNT) begin
        count_d = count_q + 8'd1;
        if (count_d == STABLE_W) begin
          accept  = 1'b1;
          state_d = HELD;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      samp_q        <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_value_q   <= '0;
      out_digit_q   <= '0;
      out_illegal_q <= 1'b0;
      digits_q      <= '0;
      overflow_q    <= 1'b0;
`ifdef SEG7_BLANK_EN
      out_blank_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      count_q <= count_d;
      if (accept) begin
        if (out_valid_q && !bus.out_ready) begin
          overflow_q <= 1'b1;
        end else begin
          out_valid_q   <= 1'b1;
          out_value_q   <= lk_value;
          out_digit_q   <= bus.seg_digit;
          out_illegal_q <= res_illegal;
`ifdef SEG7_BLANK_EN
          out_blank_q   <= is_blank;
`endif
        end
        // Shadow register tracks accepted legal glyphs even when the result is dropped.
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
          if (!lk_illegal && bus.seg_digit == 3'(k))
            digits_q[4*k +: 4] <= lk_value;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_value   = out_value_q;
  assign bus.out_digit   = out_digit_q;
  assign bus.out_illegal = out_illegal_q;
  assign digits          = digits_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_seg7_pattern_reader.sv
module tb_seg7_pattern_reader;

  logic        CLOCK_50;
  logic        resetn;
  logic [23:0] digits;
  logic        overflow;

  seg7_pattern_reader_if bus ();

  seg7_pattern_reader #(
    .STABLE_COUNT (4),
    .NUM_DIGITS   (6)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus.slave),
    .digits   (digits),
    .overflow (overflow)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int hs_cnt    = 0;
  logic [3:0] last_val;
  logic [2:0] last_dig;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Completed handshakes, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (resetn && bus.out_valid && bus.out_ready) begin
      hs_cnt   <= hs_cnt + 1;
      last_val <= bus.out_value;
      last_dig <= bus.out_digit;
    end
  end

  task automatic send(input logic [6:0] data, input logic [2:0] dig);
    @(negedge CLOCK_50);
    bus.seg_valid = 1'b1;
    bus.seg_data  = data;
    bus.seg_digit = dig;
    @(posedge CLOCK_50);
    #1;
    bus.seg_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge CLOCK_50);
    bus.seg_valid = 1'b0;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    bus.seg_valid = 1'b0;
    bus.seg_data  = '0;
    bus.seg_digit = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_value !== 4'h0) $display("FAIL reset_value got %h want 0", bus.out_value); else pass_cnt++;
    total_cnt++; if (digits !== 24'h0) $display("FAIL reset_digits got %h want 0", digits); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
    resetn = 1'b1;
    idle();
  endtask

  task automatic test_basic();
    int h0;
    h0 = hs_cnt;
    bus.out_ready = 1'b1;
    repeat (3) send(7'b0100100, 3'd2);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL basic_early got %b want 0", bus.out_valid); else pass_cnt++;
    send(7'b0100100, 3'd2);
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_value !== 4'h2) $display("FAIL basic_value got %h want 2", bus.out_value); else pass_cnt++;
    total_cnt++; if (bus.out_digit !== 3'd2) $display("FAIL basic_digit got %0d want 2", bus.out_digit); else pass_cnt++;
    total_cnt++; if (bus.out_illegal !== 1'b0) $display("FAIL basic_illegal got %b want 0", bus.out_illegal); else pass_cnt++;
    total_cnt++; if (digits[11:8] !== 4'h2) $display("FAIL basic_shadow got %h want 2", digits[11:8]); else pass_cnt++;
    idle();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL basic_fall got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (hs_cnt - h0 !== 1) $display("FAIL basic_pulses got %0d want 1", hs_cnt - h0); else pass_cnt++;
  endtask

  task automatic test_rerun();
    int h0;
    h0 = hs_cnt;
    repeat (3) send(7'b0010010, 3'd0);
    send(7'b0000010, 3'd0);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rerun_broken got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (hs_cnt - h0 !== 0) $display("FAIL rerun_none got %0d want 0", hs_cnt - h0); else pass_cnt++;
    repeat (3) send(7'b0000010, 3'd0);
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_value !== 4'h6) $display("FAIL rerun_value got %b/%h want 1/6", bus.out_valid, bus.out_value); else pass_cnt++;
    idle();
  endtask

  task automatic test_blank();
    repeat (4) send(7'b1111111, 3'd3);
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_digit !== 3'd3) $display("FAIL blank_valid got %b/%0d want 1/3", bus.out_valid, bus.out_digit); else pass_cnt++;
    total_cnt++; if (bus.out_value !== 4'h0) $display("FAIL blank_value got %h want 0", bus.out_value); else pass_cnt++;
`ifdef SEG7_BLANK_EN
    total_cnt++; if (bus.out_illegal !== 1'b0) $display("FAIL blank_illegal got %b want 0", bus.out_illegal); else pass_cnt++;
    total_cnt++; if (bus.out_blank !== 1'b1) $display("FAIL blank_flag got %b want 1", bus.out_blank); else pass_cnt++;
`else
    total_cnt++; if (bus.out_illegal !== 1'b1) $display("FAIL blank_illegal got %b want 1", bus.out_illegal); else pass_cnt++;
`endif
    total_cnt++; if (digits !== 24'h000206) $display("FAIL blank_shadow got %h want 000206", digits); else pass_cnt++;
    idle();
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    repeat (4) send(7'b1000000, 3'd0);
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_value !== 4'h0 || bus.out_digit !== 3'd0) $display("FAIL ovf_first got %b/%h/%0d want 1/0/0", bus.out_valid, bus.out_value, bus.out_digit); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", overflow); else pass_cnt++;
    repeat (4) send(7'b0001000, 3'd1);
    total_cnt++; if (bus.out_value !== 4'h0 || bus.out_digit !== 3'd0) $display("FAIL ovf_held got %h/%0d want 0/0", bus.out_value, bus.out_digit); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else pass_cnt++;
    total_cnt++; if (digits[7:4] !== 4'hA) $display("FAIL ovf_shadow got %h want A", digits[7:4]); else pass_cnt++;
    repeat (3) send(7'b1111001, 3'd4);
    bus.out_ready = 1'b1;
    send(7'b1111001, 3'd4);
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_value !== 4'h1 || bus.out_digit !== 3'd4) $display("FAIL coincide got %b/%h/%0d want 1/1/4", bus.out_valid, bus.out_value, bus.out_digit); else pass_cnt++;
    idle();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL coincide_fall got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (digits !== 24'h0102A0 || overflow !== 1'b1) $display("FAIL ovf_sticky got %h/%b want 0102A0/1", digits, overflow); else pass_cnt++;
  endtask

  task automatic test_hold();
    int h0;
    h0 = hs_cnt;
    repeat (20) send(7'b1111001, 3'd1);
    idle();
    total_cnt++; if (hs_cnt - h0 !== 1 || last_dig !== 3'd1) $display("FAIL hold_once got %0d/%0d want 1/1", hs_cnt - h0, last_dig); else pass_cnt++;
    h0 = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      send(7'b0110000, 3'd1);
      send(7'b1111111, 3'd7);
      idle();
    end
    total_cnt++; if (hs_cnt - h0 !== 1 || last_val !== 4'h3) $display("FAIL interleave got %0d/%h want 1/3", hs_cnt - h0, last_val); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int h0;
    repeat (2) send(7'b0011001, 3'd5);
    #2;
    resetn = 1'b0;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0 || digits !== 24'h0 || overflow !== 1'b0) $display("FAIL midreset got %b/%h/%b want 0/0/0", bus.out_valid, digits, overflow); else pass_cnt++;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    h0 = hs_cnt;
    repeat (2) send(7'b0011001, 3'd5);
    total_cnt++; if (bus.out_valid !== 1'b0 || hs_cnt - h0 !== 0) $display("FAIL midreset_fresh got %b/%0d want 0/0", bus.out_valid, hs_cnt - h0); else pass_cnt++;
    repeat (2) send(7'b0011001, 3'd5);
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_value !== 4'h4 || bus.out_digit !== 3'd5) $display("FAIL midreset_run got %b/%h/%0d want 1/4/5", bus.out_valid, bus.out_value, bus.out_digit); else pass_cnt++;
    total_cnt++; if (digits !== 24'h400000) $display("FAIL midreset_shadow got %h want 400000", digits); else pass_cnt++;
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rerun();
    test_blank();
    test_overflow();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seg7_pattern_reader.md
# seg7_pattern_reader

Inverse of the hex-to-seven-segment display decoder. It samples active-low segment patterns (HEX[6:0] order, bit 0 = segment a, bit 6 = segment g) arriving with a digit index and filters them for stability. Each stable pattern is converted back to its 4-bit hex value and delivered through a valid/ready output, and the block keeps a six-digit shadow register mirroring HEX0..HEX5. It sits on the display-drive path as a readback/self-check monitor.

## Interface
- STABLE_COUNT, default 4: consecutive identical samples required before a pattern is accepted; legal range 1..255.
- NUM_DIGITS, default 6: number of displays tracked; legal range 1..8.
- CLOCK_50  in  1: system clock, rising edge.
- resetn  in  1: reset; one clock, asynchronous, active-low.
- seg_valid  in  1: sample strobe for seg_data/seg_digit.
- seg_data  in  7: active-low segment pattern, g..a.
- seg_digit  in  3: display index of the sample.
- out_valid  out  1: result available.
- out_ready  in  1: consumer accepts the result.
- out_value  out  4: decoded hex value; 0 when illegal.
- out_digit  out  3: display index of the result.
- out_illegal  out  1: pattern is not in the decode table.
- digits  out  4*NUM_DIGITS: shadow register; nibble k holds the last legal value for display k.
- overflow  out  1: sticky; a result was dropped.

## Operation
- Decode table, pattern to value: 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0001000→A, 0000011→b, 1000110→C, 0100001→d, 0000110→E, 0001110→F. Any other pattern is illegal.
- Filter FSM with states IDLE, COUNT, HELD. It tracks the last sampled {seg_digit, seg_data} and an 8-bit run counter.
  - IDLE: on seg_valid with seg_digit < NUM_DIGITS, latch the sample, set count = 1, go to COUNT.
  - COUNT: on seg_valid with the same sample, increment count. A different sample relatches and sets count = 1. When count reaches STABLE_COUNT, accept and go to HELD.
  - HELD: the same sample is ignored (no re-accept). A different sample relatches, sets count = 1 and goes to COUNT.
  - STABLE_COUNT = 1: accept happens on the first sample, passing IDLE→HELD directly.
- Samples with seg_digit ≥ NUM_DIGITS are ignored entirely. They do not break a run.
- Cycles without seg_valid do not break a run.
- On accept:
  - Output register loads value, digit and illegal flag.
  - digits nibble [seg_digit] is updated only when the pattern is legal.
- Output handshake: the transfer completes on a cycle where out_valid && out_ready.
  - Accept while out_valid && !out_ready: the new result is dropped, overflow sets, and the held result is unchanged.
  - Accept on the same cycle as a completing transfer: the new result loads and out_valid stays 1.

## Timing
- Reset values: out_valid=0, out_value=0, out_digit=0, out_illegal=0, digits all 0, overflow=0, FSM in IDLE, count=0.
- Latency: out_valid rises on the clock edge following the cycle carrying the STABLE_COUNT-th matching sample. digits updates on that same edge.
- out_valid falls on the edge after a handshake unless a new accept coincides with it.
- overflow clears only on reset.
- Reset asserted mid-run: the run and the held result are lost immediately, asynchronously.

## Configuration
- SEG7_BLANK_EN defined: pattern 1111111 (all segments off) is legal "blank". The result has out_illegal=0 and out_value=0, and out_blank (1-bit output, present only under this macro) is 1 for that result. The digits nibble is not updated for blank.
- Without the macro: 1111111 is illegal like any other unmapped pattern, and no out_blank port exists.

## Structure
- Package seg7_pkg holds:
  - the 16-entry pattern constant array;
  - the blank pattern constant;
  - the FSM state enum (IDLE, COUNT, HELD).
- Sub-module seg7_pattern_lookup: purely combinational pattern→{value, illegal} lookup, reusable by other display blocks.

## Test plan
- STABLE_COUNT=4; seg_data=0100100, digit 2, four consecutive strobes, out_ready=1 → one out_valid pulse with value 2, digit 2, illegal=0; digits[11:8]=2.
- Three strobes of 0010010 then one of 0000010 → no output; three more of 0000010 → value 6.
- seg_data=1111111 for 4 strobes → illegal=1 and value 0 without SEG7_BLANK_EN; with it, out_blank=1, illegal=0, and digits unchanged.
- out_ready=0; accept 0 on digit 0, then accept 0001000 on digit 1 → result stays value 0, overflow=1, digits[7:4]=A.
- Pattern 1111001 on digit 1 held for 20 strobes → exactly one accept; strobes with seg_digit=7 interleaved → still exactly one.
- Assert resetn low during COUNT → all outputs return to reset values; a fresh full run is required for the next result.
